// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes and monitor state type for the 7-seg ring monitor
package seg7_pkg;

    // Active-low segment patterns, index 0 = seg a .. index 6 = seg g
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b1100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0001100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } mon_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational decode of an active-low segment pattern back to BCD
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [0:6] pat,
    output logic [3:0] bcd,
    output logic       valid
);

    // Inverse of the display-side digit table; anything else (blank included) is invalid
    always_comb begin
        bcd   = 4'd0;
        valid = 1'b1;
        case (pat)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_ring_monitor.sv
// rtl/seg7_ring_monitor.sv - debounced 7-seg digit sequence checker; SEG7_MON_LEDR_CHECK_EN adds the LEDR ring cross-check
module seg7_ring_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter int ERR_W         = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [0:6]       HEX,
    input  logic [9:0]       LEDR,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             locked,
    output logic             step_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] step_count,
    output logic [ERR_W-1:0] err_count
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);

    logic [0:6]       hex_q;
    logic [0:6]       acc_pat;
    logic [SW-1:0]    stab_cnt;
    logic             accept;
    logic [3:0]       dec_bcd;
    logic             dec_valid;
    logic [3:0]       exp_digit;
    logic             ledr_ok;
    mon_state_t       state;
    mon_state_t       state_n;
    logic [3:0]       digit_n;
    logic             digit_valid_n;
    logic             step_n;
    logic             err_n;
    logic [CNT_W-1:0] step_count_n;
    logic [ERR_W-1:0] err_count_n;

    seg7_to_bcd u_dec (
        .pat   (hex_q),
        .bcd   (dec_bcd),
        .valid (dec_valid)
    );

    // A new pattern is taken once it has matched its previous sample long enough
    assign accept    = (stab_cnt == SW'(STABLE_CYCLES - 1)) && (HEX == hex_q) && (hex_q != acc_pat);
    assign exp_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    assign locked    = (state == TRACK);

`ifdef SEG7_MON_LEDR_CHECK_EN
    // The ring position must agree with the digit being shown
    always_comb begin
        ledr_ok = (LEDR == (10'b1 << dec_bcd));
    end
`else
    logic unused_ledr;
    assign unused_ledr = ^LEDR;

    // Ring is not checked in this build
    always_comb begin
        ledr_ok = 1'b1;
    end
`endif

    // Sample the bus and track how long the current pattern has been steady
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hex_q    <= SEG_BLANK;
            acc_pat  <= SEG_BLANK;
            stab_cnt <= '0;
        end else begin
            hex_q <= HEX;
            if (HEX != hex_q)
                stab_cnt <= '0;
            else if (stab_cnt != SW'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + SW'(1);
            if (accept)
                acc_pat <= hex_q;
        end
    end

    // State register plus registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= SYNC;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            step_pulse  <= 1'b0;
            err_pulse   <= 1'b0;
            step_count  <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            digit       <= digit_n;
            digit_valid <= digit_valid_n;
            step_pulse  <= step_n;
            err_pulse   <= err_n;
            step_count  <= step_count_n;
            err_count   <= err_count_n;
        end
    end

    // Next-state and output decisions, evaluated only on an accept event
    always_comb begin
        state_n       = state;
        digit_n       = digit;
        digit_valid_n = digit_valid;
        step_n        = 1'b0;
        err_n         = 1'b0;
        step_count_n  = step_count;
        err_count_n   = err_count;
        if (accept) begin
            if (dec_valid && !ledr_ok) begin
                err_n         = 1'b1;
                state_n       = SYNC;
                digit_valid_n = 1'b0;
            end else begin
                case (state)
                    SYNC: begin
                        if (dec_valid) begin
                            digit_n       = dec_bcd;
                            digit_valid_n = 1'b1;
                            state_n       = TRACK;
                        end
                    end
                    TRACK: begin
                        if (!dec_valid) begin
                            err_n         = 1'b1;
                            digit_valid_n = 1'b0;
                            state_n       = SYNC;
                        end else if (dec_bcd == exp_digit) begin
                            step_n  = 1'b1;
                            digit_n = dec_bcd;
                        end else begin
                            err_n   = 1'b1;
                            digit_n = dec_bcd;
                            state_n = SYNC;
                        end
                    end
                    default: state_n = SYNC;
                endcase
            end
            if (step_n && (step_count != '1))
                step_count_n = step_count + CNT_W'(1);
            if (err_n && (err_count != '1))
                err_count_n = err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_seg7_ring_monitor.sv
// tb/tb_seg7_ring_monitor.sv - directed self-checking bench for seg7_ring_monitor
module tb_seg7_ring_monitor;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [0:6]  HEX   = 7'b1111111;
    logic [9:0]  LEDR  = 10'd0;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        locked;
    logic        step_pulse;
    logic        err_pulse;
    logic [15:0] step_count;
    logic [7:0]  err_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [0:6] seg_tab [0:9];
    logic [0:6] blank_pat;
    logic [0:6] bad_pat;

    seg7_ring_monitor dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .HEX         (HEX),
        .LEDR        (LEDR),
        .digit       (digit),
        .digit_valid (digit_valid),
        .locked      (locked),
        .step_pulse  (step_pulse),
        .err_pulse   (err_pulse),
        .step_count  (step_count),
        .err_count   (err_count)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern for 8 clocks; no pulse may appear after 4 edges, the event lands on edge 5
    task automatic put_digit(input logic [0:6] pat, input logic [9:0] ring,
                             input logic exp_step, input logic exp_err, input string tag);
        HEX  = pat;
        LEDR = ring;
        repeat (4) @(posedge Clock);
        #1;
        chk({tag, " early step"}, step_pulse, 0);
        chk({tag, " early err"}, err_pulse, 0);
        @(posedge Clock);
        #1;
        chk({tag, " step_pulse"}, step_pulse, exp_step);
        chk({tag, " err_pulse"}, err_pulse, exp_err);
        repeat (3) @(posedge Clock);
        #1;
    endtask

    function automatic logic [9:0] onehot(input int d);
        return 10'b1 << d;
    endfunction

    initial begin
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b1100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0001100;
        blank_pat  = 7'b1111111;
        bad_pat    = 7'b0101010;

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        chk("rst digit", digit, 0);
        chk("rst digit_valid", digit_valid, 0);
        chk("rst locked", locked, 0);
        chk("rst step_count", step_count, 0);
        chk("rst err_count", err_count, 0);
        Reset = 1'b0;
        repeat (6) @(posedge Clock);
        #1;
        chk("idle blank no lock", locked, 0);

        // Full 0..9..0 ring
        for (int i = 0; i <= 10; i++) begin
            put_digit(seg_tab[i % 10], onehot(i % 10), (i != 0), 1'b0, "ring");
            chk("ring digit", digit, i % 10);
            chk("ring locked", locked, 1);
            chk("ring step_count", step_count, i);
        end
        chk("ring err_count", err_count, 0);

        // 1,2,3,4 steps then skip to 6
        for (int i = 1; i <= 4; i++)
            put_digit(seg_tab[i], onehot(i), 1'b1, 1'b0, "pre-skip");
        chk("pre-skip step_count", step_count, 14);
        put_digit(seg_tab[6], onehot(6), 1'b0, 1'b1, "skip6");
        chk("skip err_count", err_count, 1);
        chk("skip locked", locked, 0);
        chk("skip digit", digit, 6);
        put_digit(seg_tab[7], onehot(7), 1'b0, 1'b0, "relock7");
        chk("relock locked", locked, 1);
        chk("relock step_count", step_count, 14);
        put_digit(seg_tab[8], onehot(8), 1'b1, 1'b0, "step8");
        chk("step8 step_count", step_count, 15);

        // Glitch filtering
        put_digit(seg_tab[9], onehot(9), 1'b1, 1'b0, "to9");
        put_digit(seg_tab[0], onehot(0), 1'b1, 1'b0, "to0");
        put_digit(seg_tab[1], onehot(1), 1'b1, 1'b0, "to1");
        put_digit(seg_tab[2], onehot(2), 1'b1, 1'b0, "to2");
        HEX = seg_tab[8];
        repeat (2) @(posedge Clock);
        #1;
        HEX = seg_tab[2];
        repeat (8) @(posedge Clock);
        #1;
        chk("glitch back step_count", step_count, 19);
        chk("glitch back digit", digit, 2);
        HEX = seg_tab[8];
        repeat (2) @(posedge Clock);
        #1;
        chk("glitch step_pulse", step_pulse, 0);
        chk("glitch err_pulse", err_pulse, 0);
        put_digit(seg_tab[3], onehot(3), 1'b1, 1'b0, "after glitch 3");
        chk("glitch step_count", step_count, 20);
        chk("glitch err_count", err_count, 1);
        chk("glitch digit", digit, 3);

        // Blank in TRACK is an error, invalid codes in SYNC are not
        put_digit(blank_pat, 10'd0, 1'b0, 1'b1, "blank track");
        chk("blank err_count", err_count, 2);
        chk("blank digit_valid", digit_valid, 0);
        chk("blank locked", locked, 0);
        put_digit(bad_pat, 10'd0, 1'b0, 1'b0, "bad sync");
        put_digit(blank_pat, 10'd0, 1'b0, 1'b0, "blank sync");
        chk("sync invalid err_count", err_count, 2);

        // Asynchronous reset in the middle of a stability window
        put_digit(seg_tab[4], onehot(4), 1'b0, 1'b0, "lock4");
        put_digit(seg_tab[5], onehot(5), 1'b1, 1'b0, "step5");
        chk("pre-reset step_count", step_count, 21);
        HEX  = seg_tab[6];
        LEDR = onehot(6);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        chk("async rst step_count", step_count, 0);
        chk("async rst err_count", err_count, 0);
        chk("async rst locked", locked, 0);
        chk("async rst digit_valid", digit_valid, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        put_digit(seg_tab[6], onehot(6), 1'b0, 1'b0, "post-reset 6");
        chk("post-reset locked", locked, 1);
        chk("post-reset digit", digit, 6);
        chk("post-reset digit_valid", digit_valid, 1);

`ifdef SEG7_MON_LEDR_CHECK_EN
        // Ring cross-check
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        put_digit(seg_tab[4], 10'b0000100000, 1'b0, 1'b1, "ledr bad");
        chk("ledr bad locked", locked, 0);
        chk("ledr bad err_count", err_count, 1);
        put_digit(blank_pat, 10'd0, 1'b0, 1'b0, "ledr blank");
        put_digit(seg_tab[4], 10'b0000010000, 1'b0, 1'b0, "ledr good");
        chk("ledr good locked", locked, 1);
        chk("ledr good err_count", err_count, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
